// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, word counts, FSM state encoding and the
// result-word packing helper used by the job dispatcher and its result
// serializer.
package miner_pkg;

    localparam int WORD_S    = 32;
    localparam int H_SIZE    = 256;
    localparam int INPUT_S   = 96;
    localparam int JOB_WORDS = 19;
    localparam int RES_WORDS = 10;
    localparam int RES_BITS  = RES_WORDS * WORD_S;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    // Result frame, word 0 in the top bits: {30'b0, timeout, found},
    // nonce, then the hash MSB-first. A miss blanks everything after word 0.
    function automatic logic [RES_BITS-1:0] pack_result(
        input logic                timeout,
        input logic                found,
        input logic [WORD_S-1:0]   nonce,
        input logic [H_SIZE-1:0]   hash
    );
        return {30'b0, timeout, found,
                found ? {nonce, hash} : {(WORD_S + H_SIZE){1'b0}}};
    endfunction

endpackage

// File: rtl/miner_job_ctrl_if.sv
// miner_job_ctrl_if: 32-bit valid/ready word stream.
//   data  : word payload
//   valid : word present (source)
//   ready : word accepted when valid && ready (sink)
//   last  : final word of a frame (source)
// master = source side, slave = sink side.
interface miner_job_ctrl_if;
    import miner_pkg::*;

    logic [WORD_S-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/miner_res_ser.sv
// miner_res_ser: 10 x 32-bit load-then-shift result serializer.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data and start presenting word 0
//   load_data  : packed frame, word 0 in the top bits
//   res_out    : result stream (master); last flags word 9
//   done       : pulses on the cycle word 9 is accepted
module miner_res_ser
    import miner_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [RES_BITS-1:0]  load_data,
    miner_job_ctrl_if.master     res_out,
    output logic                 done
);

    logic [RES_BITS-1:0] shreg;
    logic [3:0]          cnt;
    logic                valid_q;
    logic                accept;
    logic                at_last;

    assign accept  = valid_q && res_out.ready;
    assign at_last = (cnt == 4'(RES_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg   <= load_data;
            cnt     <= '0;
            valid_q <= 1'b1;
        end else if (accept) begin
            if (at_last) begin
                // leave m_data at zero while idle
                shreg   <= '0;
                cnt     <= '0;
                valid_q <= 1'b0;
            end else begin
                shreg <= {shreg[RES_BITS-WORD_S-1:0], {WORD_S{1'b0}}};
                cnt   <= cnt + 4'd1;
            end
        end
    end

    assign res_out.data  = shreg[RES_BITS-1 -: WORD_S];
    assign res_out.valid = valid_q;
    assign res_out.last  = valid_q && at_last;
    assign done          = accept && at_last;

endmodule

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: job dispatcher / result collector for the mining core.
// Assembles a 19-word job (target, midstate, header tail) MSB-first,
// pulses miner_en once, waits for miner_done, and returns a 10-word result.
//   clk, reset      : clock, synchronous active-high reset
//   job_in          : job word stream (slave)
//   res_out         : result word stream (master), last on word 9
//   busy            : high in START/WAIT/SEND
//   miner_en        : one-cycle start pulse
//   miner_prev_blk/miner_prev_H/miner_input_M : registered job fields
//   miner_done/found/nonce/winner_H           : core result
//   miner_abort     : core reset request on watchdog expiry
// Optional feature macro MINER_TIMEOUT_EN adds the WAIT watchdog and the
// miner_abort port; without it WAIT waits indefinitely.
//
// state | meaning
// LOAD  | accepting job words
// START | miner_en pulse
// WAIT  | job held, waiting for core done (or watchdog)
// SEND  | streaming the 10 result words
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 40,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 40'hFF_FFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    miner_job_ctrl_if.slave     job_in,
    miner_job_ctrl_if.master    res_out,
    output logic                busy,
    output logic                miner_en,
    output logic [H_SIZE-1:0]   miner_prev_blk,
    output logic [H_SIZE-1:0]   miner_prev_H,
    output logic [INPUT_S-1:0]  miner_input_M,
    input  logic                miner_done,
    input  logic                miner_found,
    input  logic [WORD_S-1:0]   miner_nonce,
    input  logic [H_SIZE-1:0]   miner_winner_H
`ifdef MINER_TIMEOUT_EN
    ,
    output logic                miner_abort
`endif
);

    state_t              state, state_nxt;
    logic [4:0]          idx;
    logic                ready_q;
    logic                job_acc;
    logic                job_last;
    logic                tmo_hit;
    logic                ser_load;
    logic                ser_done;
    logic [RES_BITS-1:0] ser_data;
    logic                unused_ok;

    // ready is registered so it rises on the first edge after reset and
    // on the edge that completes the result stream.
    assign job_in.ready = ready_q;
    assign job_acc      = job_in.valid && ready_q;
    assign job_last     = (idx == 5'(JOB_WORDS - 1));

`ifdef MINER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || state == ST_START) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
    end

    // Counter reads k-1 in WAIT cycle k; done in the same cycle wins.
    assign tmo_hit     = (state == ST_WAIT) && !miner_done &&
                         (tmo_cnt == TIMEOUT_CYCLES - TIMEOUT_W'(1));
    assign miner_abort = tmo_hit;
    assign unused_ok   = job_in.last;
`else
    assign tmo_hit   = 1'b0;
    assign unused_ok = ^{job_in.last, TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_LOAD;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_LOAD);
        end
    end

    always_comb begin
        state_nxt = state;
        ser_load  = 1'b0;
        case (state)
            ST_LOAD:  if (job_acc && job_last) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (miner_done || tmo_hit) begin
                    state_nxt = ST_SEND;
                    ser_load  = 1'b1;
                end
            end
            ST_SEND:  if (ser_done) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // All 608 job bits form one shift register: after 19 words, word 0 sits
    // at the top of prev_blk and word 18 at the bottom of input_M.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= '0;
            miner_prev_blk <= '0;
            miner_prev_H   <= '0;
            miner_input_M  <= '0;
        end else if (job_acc) begin
            idx <= job_last ? 5'd0 : idx + 5'd1;
            {miner_prev_blk, miner_prev_H, miner_input_M} <=
                {miner_prev_blk[H_SIZE-WORD_S-1:0], miner_prev_H,
                 miner_input_M, job_in.data};
        end
    end

    assign ser_data = pack_result(tmo_hit, miner_done && miner_found,
                                  miner_nonce, miner_winner_H);

    miner_res_ser u_res_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_data),
        .res_out   (res_out),
        .done      (ser_done)
    );

    assign busy     = (state != ST_LOAD);
    assign miner_en = (state == ST_START);

endmodule

// File: tb/tb_miner_job_ctrl.sv
// tb_miner_job_ctrl: table-driven and randomized bench for miner_job_ctrl.
// Build with MINER_TIMEOUT_EN defined to add the watchdog sequences.
module tb_miner_job_ctrl;
    import miner_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    miner_job_ctrl_if job_if ();
    miner_job_ctrl_if res_if ();

    logic         busy, miner_en;
    logic [255:0] prev_blk, prev_H;
    logic [95:0]  input_M;
    logic         done, found;
    logic [31:0]  nonce;
    logic [255:0] win_H;
`ifdef MINER_TIMEOUT_EN
    logic         abort;
`endif

    miner_job_ctrl #(
        .TIMEOUT_W (40)
`ifdef MINER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (40'd100)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .job_in         (job_if),
        .res_out        (res_if),
        .busy           (busy),
        .miner_en       (miner_en),
        .miner_prev_blk (prev_blk),
        .miner_prev_H   (prev_H),
        .miner_input_M  (input_M),
        .miner_done     (done),
        .miner_found    (found),
        .miner_nonce    (nonce),
        .miner_winner_H (win_H)
`ifdef MINER_TIMEOUT_EN
        , .miner_abort  (abort)
`endif
    );

    int tests = 0;
    int fails = 0;
    int en_count = 0;

    always @(negedge clk) if (miner_en === 1'b1) en_count <= en_count + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result frame straight from the word layout rules.
    function automatic void model_result(input bit f, input bit tmo, input logic [31:0] n,
                                         input logic [255:0] h, output logic [31:0] e [10]);
        e[0] = {30'b0, tmo, f};
        e[1] = f ? n : 32'h0;
        for (int k = 0; k < 8; k++) e[2+k] = f ? h[255-32*k -: 32] : 32'h0;
    endfunction

    // Presents 19 words; returns at the START cycle after checking it.
    task automatic run_job(input logic [31:0] w [19], input bit gaps);
        logic [255:0] eb, eh;
        logic [95:0]  em;
        int i = 0;
        int budget = 2000;
        while (i < 19 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gaps && $urandom_range(0, 2) == 0) begin
                job_if.valid = 1'b0;
            end else begin
                job_if.valid = 1'b1;
                job_if.data  = w[i];
                if (job_if.ready) i++;
            end
        end
        if (i < 19) chk("job_load_budget", 256'(i), 256'd19);
        @(negedge clk);
        job_if.valid = 1'b0;
        job_if.data  = $urandom;
        for (int k = 0; k < 8; k++) begin
            eb[255-32*k -: 32] = w[k];
            eh[255-32*k -: 32] = w[8+k];
        end
        for (int k = 0; k < 3; k++) em[95-32*k -: 32] = w[16+k];
        chk("en_in_start", miner_en, 1'b1);
        chk("busy_in_start", busy, 1'b1);
        chk("ready_in_start", job_if.ready, 1'b0);
        chk("prev_blk", prev_blk, eb);
        chk("prev_H", prev_H, eh);
        chk("input_M", input_M, em);
    endtask

    task automatic core_done(input int d, input bit f, input logic [31:0] n, input logic [255:0] h);
        @(negedge clk);
        chk("en_low_in_wait", miner_en, 1'b0);
        repeat (d) @(negedge clk);
        done = 1'b1; found = f; nonce = n; win_H = h;
        @(negedge clk);
        done = 1'b0; found = $urandom; nonce = $urandom; win_H = {8{$urandom}};
        chk("first_word_latency", res_if.valid, 1'b1);
    endtask

    // mode 0: ready held high, 1: toggle 1/0, 2: random
    task automatic recv(input logic [31:0] e [10], input int mode, output logic [31:0] got [10]);
        int k = 0;
        int cyc = 0;
        int budget = 500;
        bit stalled = 0;
        bit tog = 1;
        bit r;
        logic [31:0] held = '0;
        while (k < 10 && budget > 0) begin
            if (stalled) chk("hold_while_stalled", {res_if.valid, res_if.data}, {1'b1, held});
            case (mode)
                0:       r = 1'b1;
                1:       begin r = tog; tog = ~tog; end
                default: r = 1'($urandom_range(0, 1));
            endcase
            res_if.ready = r;
            stalled = 0;
            if (res_if.valid && r) begin
                got[k] = res_if.data;
                chk($sformatf("res_word%0d", k), res_if.data, e[k]);
                chk($sformatf("res_last%0d", k), res_if.last, 1'(k == 9));
                k++;
            end else if (res_if.valid) begin
                stalled = 1;
                held = res_if.data;
            end
            cyc++;
            budget--;
            @(negedge clk);
        end
        res_if.ready = 1'b0;
        if (k < 10) chk("recv_budget", 256'(k), 256'd10);
        if (mode == 0) chk("stream_cycles", 256'(cyc), 256'd10);
        chk("valid_after_stream", res_if.valid, 1'b0);
        chk("busy_after_stream", busy, 1'b0);
        chk("ready_after_stream", job_if.ready, 1'b1);
    endtask

    typedef struct {
        bit           found;
        logic [31:0]  nonce;
        logic [255:0] hash;
        int           mode;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w1;
        logic [31:0]  exp_w9;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] w [19];
        logic [31:0] e [10];
        logic [31:0] got [10];
        int en0;
        int hits;
        int hit_at;

        vecs[0] = '{1'b1, 32'hFFFF_FFF7, 256'hAB, 0, 32'h1, 32'hFFFF_FFF7, 32'hAB};
        vecs[1] = '{1'b0, 32'h1234_5678, {8{32'hDEAD_BEEF}}, 0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 32'hCAFE_BABE,
                    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                    1, 32'h1, 32'hCAFE_BABE, 32'h8888_8888};
        vecs[3] = '{1'b1, 32'h0000_0001, {256{1'b1}}, 2, 32'h1, 32'h1, 32'hFFFF_FFFF};

        reset = 1'b1;
        job_if.valid = 1'b0; job_if.data = '0; job_if.last = 1'b0;
        res_if.ready = 1'b0;
        done = 1'b0; found = 1'b0; nonce = '0; win_H = '0;
        repeat (3) @(negedge clk);

        chk("rst_s_ready", job_if.ready, 1'b0);
        chk("rst_m_valid", res_if.valid, 1'b0);
        chk("rst_m_last", res_if.last, 1'b0);
        chk("rst_m_data", res_if.data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_en", miner_en, 1'b0);
        chk("rst_prev_blk", prev_blk, 256'h0);
`ifdef MINER_TIMEOUT_EN
        chk("rst_abort", abort, 1'b0);
`endif
        reset = 1'b0;
        #1 chk("ready_before_first_edge", job_if.ready, 1'b0);
        @(negedge clk);
        chk("ready_after_first_edge", job_if.ready, 1'b1);

        // spurious done while idle
        done = 1'b1; found = 1'b1; nonce = 32'h5A5A_5A5A;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("spurious_done_valid", res_if.valid, 1'b0);
        chk("spurious_done_busy", busy, 1'b0);

        // partial job then reset: partial words discarded
        for (int i = 0; i < 5;) begin
            @(negedge clk);
            job_if.valid = 1'b1; job_if.data = $urandom;
            if (job_if.ready) i++;
        end
        @(negedge clk);
        job_if.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("partial_job_cleared", prev_blk, 256'h0);

        // table-driven jobs
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 19; i++) w[i] = (t == 0) ? 32'(i + 1) : $urandom;
            en0 = en_count;
            run_job(w, bit'(t % 2));
            if (t == 0) begin
                chk("tp_prev_blk", prev_blk,
                    256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
                chk("tp_prev_H", prev_H,
                    256'h00000009_0000000a_0000000b_0000000c_0000000d_0000000e_0000000f_00000010);
                chk("tp_input_M", input_M, 96'h00000011_00000012_00000013);
            end
            core_done(t, vecs[t].found, vecs[t].nonce, vecs[t].hash);
            model_result(vecs[t].found, 1'b0, vecs[t].nonce, vecs[t].hash, e);
            recv(e, vecs[t].mode, got);
            chk("tbl_w0", got[0], vecs[t].exp_w0);
            chk("tbl_w1", got[1], vecs[t].exp_w1);
            chk("tbl_w9", got[9], vecs[t].exp_w9);
            chk("en_pulse_count", 256'(en_count - en0), 256'd1);
        end

        // reset during WAIT, then a done that arrives in LOAD
        for (int i = 0; i < 19; i++) w[i] = $urandom;
        run_job(w, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wait_busy", busy, 1'b0);
        chk("rst_wait_prev_H", prev_H, 256'h0);
        done = 1'b1; found = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait_no_output", res_if.valid, 1'b0);

        // reset mid-result
        for (int i = 0; i < 19; i++) w[i] = $urandom;
        run_job(w, 1'b0);
        core_done(1, 1'b1, 32'h0BAD_F00D, {8{32'h1357_9BDF}});
        res_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        res_if.ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_send_valid", res_if.valid, 1'b0);
        chk("rst_send_data", res_if.data, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_send_quiet", {res_if.valid, busy}, 2'b00);

        // randomized jobs against the model
        for (int t = 0; t < 6; t++) begin
            bit           f;
            logic [31:0]  n;
            logic [255:0] h;
            for (int i = 0; i < 19; i++) w[i] = $urandom;
            f = 1'($urandom_range(0, 1));
            n = $urandom;
            for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom;
            en0 = en_count;
            run_job(w, 1'b1);
            core_done($urandom_range(0, 6), f, n, h);
            model_result(f, 1'b0, n, h, e);
            recv(e, $urandom_range(0, 2), got);
            chk("rnd_en_pulse_count", 256'(en_count - en0), 256'd1);
        end

`ifdef MINER_TIMEOUT_EN
        // core never answers: abort in WAIT cycle 100
        for (int i = 0; i < 19; i++) w[i] = $urandom;
        run_job(w, 1'b0);
        hits = 0; hit_at = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (abort === 1'b1) begin hits++; hit_at = k; end
        end
        chk("abort_pulses", 256'(hits), 256'd1);
        chk("abort_cycle", 256'(hit_at), 256'd100);
        @(negedge clk);
        chk("abort_low_after", abort, 1'b0);
        chk("timeout_first_word", res_if.valid, 1'b1);
        model_result(1'b0, 1'b1, 32'h0, 256'h0, e);
        recv(e, 0, got);
        chk("timeout_w0", got[0], 32'h2);

        // done on the expiry cycle wins
        for (int i = 0; i < 19; i++) w[i] = $urandom;
        run_job(w, 1'b0);
        repeat (100) @(negedge clk);
        done = 1'b1; found = 1'b1; nonce = 32'h7777_0001; win_H = {8{32'h2468_ACE0}};
        #1 chk("abort_suppressed_by_done", abort, 1'b0);
        @(negedge clk);
        done = 1'b0;
        model_result(1'b1, 1'b0, 32'h7777_0001, {8{32'h2468_ACE0}}, e);
        recv(e, 0, got);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/miner_job_ctrl.md
# miner_job_ctrl

Job dispatcher and result collector on the initiator side of the mining core's job interface. It assembles a 608-bit job (target, midstate, header tail) from a 32-bit word stream and launches one search with a single-cycle enable pulse. It then holds the job stable, captures the core's done/found/nonce/hash result, and returns it as a 10-word stream. It sits between the host-facing stream fabric and `sha_top`.

## Interface
- `TIMEOUT_W`, 40: watchdog counter width; used only with `MINER_TIMEOUT_EN`.
- `TIMEOUT_CYCLES`, 40'hFF_FFFF_FFFF: WAIT cycles before abort; used only with `MINER_TIMEOUT_EN`.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `s_data`  in  32  job word.
- `s_valid`  in  1  job word valid.
- `s_ready`  out  1  job word accepted when `s_valid && s_ready`.
- `m_data`  out  32  result word.
- `m_valid`  out  1  result word valid.
- `m_ready`  in  1  downstream accepts.
- `m_last`  out  1  high on result word 9.
- `busy`  out  1  high in START/WAIT/SEND.
- `miner_en`  out  1  one-cycle start pulse to the core.
- `miner_prev_blk`  out  256  target.
- `miner_prev_H`  out  256  midstate.
- `miner_input_M`  out  96  header tail.
- `miner_done`  in  1  core done pulse.
- `miner_found`  in  1  core found, valid with `miner_done`.
- `miner_nonce`  in  32  winning nonce, valid with `miner_done`.
- `miner_winner_H`  in  256  winning hash, valid with `miner_done`.
- `miner_abort`  out  1  one-cycle core-reset request; exists only with `MINER_TIMEOUT_EN`.

## Operation
- States: LOAD, START, WAIT, SEND. Reset state is LOAD.
- LOAD: `s_ready`=1. Job words are taken MSB-first.
  - Words 0–7 → `prev_blk[255:0]`.
  - Words 8–15 → `prev_H`.
  - Words 16–18 → `input_M`.
  - A 5-bit index counts accepted words. Acceptance of word 18 → START.
- START: `miner_en`=1 for exactly this cycle → WAIT.
- WAIT: on `miner_done`=1, capture `found`, `nonce` and `winner_H` → SEND.
  - `miner_done` is ignored in LOAD, START and SEND.
- SEND: 10 words, each advancing on `m_valid && m_ready`.
  - Word 0 = {30'b0, timeout, found}.
  - Word 1 = nonce.
  - Words 2–9 = `winner_H` MSB-first.
  - With found=0, words 1–9 are 0.
  - Acceptance of word 9 → LOAD with index 0.
- The `miner_*` job outputs are registers. They change only on word acceptance in LOAD and are therefore stable from START until the next job load.
- `m_data`/`m_valid` hold while `m_ready`=0; no word is dropped or repeated.

## Timing
- Reset values: `s_ready`, `m_valid`, `m_last`, `busy`, `miner_en`, `miner_abort` = 0; `m_data` and all job/result registers = 0.
- `s_ready` rises on the first edge after `reset` deasserts.
- Last job word accepted at edge N → `miner_en`=1 during cycle N+1.
- `miner_done` sampled at edge D → `m_valid`=1 with word 0 during cycle D+1.
- Result stream: 10 cycles minimum with `m_ready` held high.
- LOAD re-entry: `s_ready`=1 the cycle after word 9 is accepted.
- Reset mid-job or mid-result: immediate return to LOAD with reset values; partial job discarded; no result emitted.

## Configuration
- `MINER_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit counter clears in START and increments in WAIT.
  - On reaching `TIMEOUT_CYCLES` with no `miner_done`: `miner_abort`=1 for one cycle, then SEND with timeout=1, found=0, words 1–9 = 0.
  - `miner_done` in the same cycle as expiry wins: normal result, timeout=0.
- Undefined: no counter and no `miner_abort` port; WAIT waits indefinitely; timeout bit is constant 0.

## Structure
- Shared package `miner_pkg` holds:
  - WORD_S=32, H_SIZE=256, INPUT_S=96.
  - JOB_WORDS=19, RES_WORDS=10.
  - State encoding.
- One sub-module, `miner_res_ser`: a 10×32 load-then-shift result serializer with valid/ready and last. The FSM, job assembly and watchdog stay in `miner_job_ctrl`.

## Test plan
- Job words 0x00000001..0x00000013 → `miner_prev_blk` = words 1..8, `miner_prev_H` = words 9..16, `miner_input_M` = {0x11,0x12,0x13}; exactly one `miner_en` pulse, one cycle after word 0x13 is accepted.
- Core model returns done, found=1, nonce=0xFFFFFFF7, hash=0x0000…00AB → words 0x1, 0xFFFFFFF7, 0x0 ×7, 0x000000AB; `m_last` only on the final word.
- Done with found=0 → ten words: 0x0 ×10.
- `m_ready` toggled 1/0 each cycle during SEND → same ten words in order, each held while stalled; `busy` drops after word 9.
- Spurious `miner_done` in LOAD, plus reset during WAIT → no output; the next full job runs correctly.
- With `MINER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, core never done → `miner_abort` pulse at WAIT cycle 100; word 0 = 0x2, words 1–9 = 0.
